// File: rtl/vga_frame_capture.sv
// VGA frame capture: locks onto incoming sync timing and streams one thresholded bit per active
// pixel to a VRAM write port in row-major order.
module vga_frame_capture #(
    parameter int unsigned ACTIVE_COLUMNS  = 640,
    parameter int unsigned ACTIVE_ROWS     = 480,
    parameter int unsigned H_BACK_PORCH    = 48,
    parameter int unsigned V_BACK_PORCH    = 33,
    parameter int unsigned LUMA_THRESHOLD  = 24,
    parameter int unsigned VRAM_ADDR_WIDTH = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pixel_tick_i,
    input  logic                       hsync_i,
    input  logic                       vsync_i,
    input  logic [3:0]                 vga_red_i,
    input  logic [3:0]                 vga_green_i,
    input  logic [3:0]                 vga_blue_i,
    input  logic                       capture_en_i,
    output logic                       wr_en_o,
    output logic [VRAM_ADDR_WIDTH-1:0] wr_address_o,
    output logic                       wr_data_o,
    output logic                       frame_done_o,
    output logic                       error_o,
    output logic                       locked_o
);

    localparam int unsigned COL_W  = (ACTIVE_COLUMNS > 1) ? $clog2(ACTIVE_COLUMNS) : 1;
    localparam int unsigned ROW_W  = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
    localparam int unsigned LINE_W = (V_BACK_PORCH > 0) ? $clog2(V_BACK_PORCH + 1) : 1;
    localparam int unsigned HP_W   = (H_BACK_PORCH > 0) ? $clog2(H_BACK_PORCH + 1) : 1;

    localparam logic [2:0] StUnlocked = 3'd0;
    localparam logic [2:0] StVsync    = 3'd1;
    localparam logic [2:0] StVPorch   = 3'd2;
    localparam logic [2:0] StHWait    = 3'd3;
    localparam logic [2:0] StHPorch   = 3'd4;
    localparam logic [2:0] StActive   = 3'd5;

    localparam logic [COL_W-1:0]  LastCol  = COL_W'(ACTIVE_COLUMNS - 1);
    localparam logic [ROW_W-1:0]  LastRow  = ROW_W'(ACTIVE_ROWS - 1);
    localparam logic [LINE_W-1:0] LastLine = LINE_W'(V_BACK_PORCH - 1);
    localparam logic [HP_W-1:0]   LastHp   = HP_W'(H_BACK_PORCH - 1);

    logic                       vs_q, vs_prev_q, hs_q, hs_prev_q;
    logic [3:0]                 red_q, green_q, blue_q;
    logic [2:0]                 state_q, state_d;
    logic [LINE_W-1:0]          line_q, line_d;
    logic [HP_W-1:0]            hp_q, hp_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [VRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [VRAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                       frame_en_q, frame_en_d;
    logic                       wr_en_q, wr_en_d;
    logic                       wr_data_q, wr_data_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       locked_q, locked_d;

    logic       vs_fall, vs_rise, hs_fall, hs_rise;
    logic [5:0] luma_sum;
    logic       pixel_set;
    logic       last_pixel;

    // Edges compare the last registered sample with the one from the tick before it.
    assign vs_fall    = vs_prev_q & ~vs_q;
    assign vs_rise    = ~vs_prev_q & vs_q;
    assign hs_fall    = hs_prev_q & ~hs_q;
    assign hs_rise    = ~hs_prev_q & hs_q;
    assign luma_sum   = {2'b00, red_q} + {2'b00, green_q} + {2'b00, blue_q};
    assign pixel_set  = luma_sum >= 6'(LUMA_THRESHOLD);
    assign last_pixel = (col_q == LastCol) && (row_q == LastRow);

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        hp_d       = hp_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        frame_en_d = frame_en_q;
        wr_data_d  = wr_data_q;
        locked_d   = locked_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (pixel_tick_i) begin
            case (state_q)
                StUnlocked: begin
                    if (vs_fall) state_d = StVsync;
                end
                StVsync: begin
                    if (vs_rise) begin
                        state_d    = StVPorch;
                        line_d     = '0;
                        addr_d     = '0;
                        frame_en_d = capture_en_i;
                    end
                end
                default: begin
                    if (vs_fall) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = StVsync;
                    end else begin
                        case (state_q)
                            StVPorch: begin
                                if (hs_rise) begin
                                    line_d = line_q + 1'b1;
                                    if (line_q == LastLine) begin
                                        state_d = StHWait;
                                        row_d   = '0;
                                    end
                                end
                            end
                            StHWait: begin
                                // The rising-edge tick itself is the first back-porch tick.
                                if (hs_rise) begin
                                    col_d = '0;
                                    hp_d  = HP_W'(1);
                                    state_d = (H_BACK_PORCH > 1) ? StHPorch : StActive;
                                end
                            end
                            StHPorch: begin
                                hp_d = hp_q + 1'b1;
                                if (hp_q == LastHp) begin
                                    state_d = StActive;
                                    col_d   = '0;
                                end
                            end
                            StActive: begin
                                if (hs_fall) begin
                                    err_d    = 1'b1;
                                    locked_d = 1'b0;
                                    state_d  = StUnlocked;
                                end else begin
                                    wr_en_d   = frame_en_q;
                                    wr_data_d = pixel_set;
                                    wr_addr_d = addr_q;
                                    if (!last_pixel) addr_d = addr_q + 1'b1;
                                    if (col_q == LastCol) begin
                                        col_d = '0;
                                        if (row_q == LastRow) begin
                                            done_d   = 1'b1;
                                            locked_d = 1'b1;
                                            state_d  = StVsync;
                                        end else begin
                                            row_d   = row_q + 1'b1;
                                            state_d = StHWait;
                                        end
                                    end else begin
                                        col_d = col_q + 1'b1;
                                    end
                                end
                            end
                            default: state_d = StUnlocked;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vs_q       <= 1'b1;
            vs_prev_q  <= 1'b1;
            hs_q       <= 1'b1;
            hs_prev_q  <= 1'b1;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            state_q    <= StUnlocked;
            line_q     <= '0;
            hp_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            frame_en_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            if (pixel_tick_i) begin
                vs_q      <= vsync_i;
                vs_prev_q <= vs_q;
                hs_q      <= hsync_i;
                hs_prev_q <= hs_q;
                red_q     <= vga_red_i;
                green_q   <= vga_green_i;
                blue_q    <= vga_blue_i;
            end
            state_q    <= state_d;
            line_q     <= line_d;
            hp_q       <= hp_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            frame_en_q <= frame_en_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_address_o = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_done_o = done_q;
    assign error_o      = err_q;
    assign locked_o     = locked_q;

endmodule
